instruction_fetch_unit: RTL

- Front end of the RSICV_CPU core. Owns the architectural fetch PC and issues word requests to the instruction memory port over a valid/ready request channel.
- Accepts in-order responses and buffers {PC, instruction} pairs in a small FIFO.
- Presents them to the decode/execute stage (DATA_PATH) over a valid/ready handshake.
- Control-flow changes (jal, jalr, taken branch) arrive as a redirect. The redirect flushes buffered and in-flight fetches, then restarts fetching at the target.

---
 rtl/instruction_fetch_unit_pkg.sv | 25 ++
 rtl/instruction_fetch_unit_fetch_fifo.sv | 73 +++++++
 rtl/instruction_fetch_unit.sv | 132 +++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared constants and types for the RSICV_CPU fetch front end.
// Holds the reset fetch address, ISA widths and the buffered fetch entry layout.
package instruction_fetch_unit_pkg;

  localparam int          XLEN              = 32;
  localparam int          ILEN_BYTES        = 4;
  localparam logic [31:0] START_INS_ADDRESS = 32'h0000_0000;
  localparam logic [31:0] INSTR_NOP         = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return |addr[1:0];
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_fetch_fifo.sv
// Small synchronous FIFO buffering {PC, instruction} pairs for the fetch unit.
// Flush beats push and pop; a pop in the same cycle frees the slot for a push when full.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  parameter int CNT_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign do_push = push_i && !flush_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is only observed while the count is non-zero.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch front end: owns the fetch PC, issues word requests under a credit limit,
// buffers in-order responses and hands {PC, instruction} to DATA_PATH.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] START_ADDR = START_INS_ADDRESS,
  parameter int          FIFO_DEPTH = 2,
  parameter int          CNT_W      = 2
) (
  input  logic        SYS_clk,
  input  logic        SYS_reset_n,
  output logic        IMEM_req_valid,
  input  logic        IMEM_req_ready,
  output logic [31:0] IMEM_req_address,
  input  logic        IMEM_resp_valid,
  input  logic [31:0] IMEM_resp_data,
  output logic        IF_valid,
  input  logic        IF_ready,
  output logic [31:0] IF_instruction,
  output logic [31:0] IF_PC,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_PC,
  output logic        IF_fault
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; valid
  // never waits on ready, and the payload is only meaningful while valid is high.

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] discard_q, discard_d;
  logic             fault_q, fault_d;

  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty;
  logic             fifo_full;
  logic             fifo_push;
  logic             fifo_pop;
  logic [ENTRY_W-1:0] fifo_rdata;
  fetch_entry_t     push_entry;
  fetch_entry_t     head_entry;
  logic [CNT_W:0]   in_flight;
  logic             req_fire;

  // Every slot is reserved at request time, so a response always finds room.
  assign in_flight      = {1'b0, outstanding_q} + {1'b0, fifo_count};
  assign IMEM_req_valid = SYS_reset_n && !fault_q && !redirect_valid &&
                          (in_flight < (CNT_W+1)'(FIFO_DEPTH));
  assign IMEM_req_address = fetch_pc_q;
  assign req_fire       = IMEM_req_valid && IMEM_req_ready;

  assign fifo_push = IMEM_resp_valid && !redirect_valid && (discard_q == '0);
  assign fifo_pop  = IF_valid && IF_ready && !redirect_valid;

  assign push_entry.pc    = resp_pc_q;
  assign push_entry.instr = IMEM_resp_data;
  assign head_entry       = fetch_entry_t'(fifo_rdata);

  assign IF_valid       = !fifo_empty;
  assign IF_PC          = fifo_empty ? '0 : head_entry.pc;
  assign IF_instruction = fifo_empty ? '0 : head_entry.instr;
  assign IF_fault       = fault_q;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk_i   (SYS_clk),
    .rst_ni  (SYS_reset_n),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .flush_i (redirect_valid),
    .wdata_i (push_entry),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    fault_d       = fault_q;

    case ({req_fire, IMEM_resp_valid})
      2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
      2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase

    if (redirect_valid) begin
      // Everything still in flight is stale; a response landing now is dropped too.
      fetch_pc_d = word_align(redirect_PC);
      resp_pc_d  = word_align(redirect_PC);
      discard_d  = outstanding_q - CNT_W'(IMEM_resp_valid);
      fault_d    = is_misaligned(redirect_PC);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + 32'(ILEN_BYTES);
      if (IMEM_resp_valid) begin
        if (discard_q != '0) discard_d = discard_q - CNT_W'(1);
        else                 resp_pc_d = resp_pc_q + 32'(ILEN_BYTES);
      end
    end
  end

  always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
    if (!SYS_reset_n) begin
      fetch_pc_q    <= START_ADDR;
      resp_pc_q     <= START_ADDR;
      outstanding_q <= '0;
      discard_q     <= '0;
      fault_q       <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      fault_q       <= fault_d;
    end
  end

  resp_needs_request: assert property (@(posedge SYS_clk) disable iff (!SYS_reset_n)
    IMEM_resp_valid |-> (outstanding_q != '0));

  no_fifo_overflow: assert property (@(posedge SYS_clk) disable iff (!SYS_reset_n)
    (fifo_push && fifo_full) |-> fifo_pop);

endmodule
